// File: rtl/psum_drain_wb.sv
// psum_drain_wb -- drains partial-sum vectors from an output FIFO, sums each
// group of WINDOW_SIZE consecutive vectors lane by lane with saturation,
// optionally applies ReLU, and writes one result vector per window to PMEM.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   start               one-cycle pulse that launches a job (ignored unless idle)
//   relu_en, base_addr,
//   num_out             job parameters, captured on start
//   ofifo_valid/data    show-ahead OFIFO head; ofifo_rd pops it
//   pmem_wr/addr/data   PMEM write port; addr/data hold the last write when idle
//   busy                high whenever a job is in progress
//   done                one-cycle pulse at the end of every job
module psum_drain_wb #(
   parameter int col         = 8,
   parameter int psum_bw     = 16,
   parameter int WINDOW_SIZE = 3,
   parameter int addr_bw     = 11
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   relu_en,
   input  logic [addr_bw-1:0]     base_addr,
   input  logic [7:0]             num_out,
   input  logic                   ofifo_valid,
   input  logic [col*psum_bw-1:0] ofifo_data,
   output logic                   ofifo_rd,
   output logic                   pmem_wr,
   output logic [addr_bw-1:0]     pmem_addr,
   output logic [col*psum_bw-1:0] pmem_data,
   output logic                   busy,
   output logic                   done
);
   localparam int DW    = col * psum_bw;
   localparam int WIN_W = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_SIZE - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WRITE, ST_DONE} state_t;

   state_t             state_reg, state_next;
   logic [addr_bw-1:0] addr_reg, hold_addr_reg;
   logic [DW-1:0]      hold_data_reg, wr_data;
   logic [7:0]         out_cnt_reg, num_out_reg;
   logic [WIN_W-1:0]   win_cnt_reg;
   logic               relu_reg;
   logic               accept, window_first, window_last;

   assign accept       = (state_reg == ST_RUN) && ofifo_valid;
   assign window_first = (win_cnt_reg == '0);
   assign window_last  = (win_cnt_reg == WIN_LAST);

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:  if (start) state_next = (num_out == 8'd0) ? ST_DONE : ST_RUN;
         ST_RUN:   if (accept && window_last) state_next = ST_WRITE;
         // num_out_reg is at least 1 here, so the subtraction cannot wrap.
         ST_WRITE: state_next = (out_cnt_reg == num_out_reg - 8'd1) ? ST_DONE : ST_RUN;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   // Outside WRITE the PMEM address/data ports show the last written values.
   always_comb begin
      ofifo_rd  = accept;
      pmem_wr   = 1'b0;
      pmem_addr = hold_addr_reg;
      pmem_data = hold_data_reg;
      busy      = (state_reg != ST_IDLE);
      done      = 1'b0;
      case (state_reg)
         ST_WRITE: begin
            pmem_wr   = 1'b1;
            pmem_addr = addr_reg;
            pmem_data = wr_data;
         end
         ST_DONE:  done = 1'b1;
         default:  ;
      endcase
   end

   // ---------------- job bookkeeping ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         addr_reg      <= '0;
         hold_addr_reg <= '0;
         hold_data_reg <= '0;
         out_cnt_reg   <= '0;
         num_out_reg   <= '0;
         win_cnt_reg   <= '0;
         relu_reg      <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  addr_reg    <= base_addr;
                  out_cnt_reg <= '0;
                  win_cnt_reg <= '0;
                  relu_reg    <= relu_en;
                  num_out_reg <= num_out;
               end
            end
            ST_RUN: begin
               if (accept) win_cnt_reg <= window_last ? '0 : win_cnt_reg + 1'b1;
            end
            ST_WRITE: begin
               addr_reg      <= addr_reg + 1'b1;   // wraps naturally
               out_cnt_reg   <= out_cnt_reg + 8'd1;
               hold_addr_reg <= addr_reg;
               hold_data_reg <= wr_data;
            end
            default: ;
         endcase
      end
   end

   // ---------------- per-lane accumulate / saturate / ReLU ----------------
   generate
      for (genvar gi = 0; gi < col; gi++) begin : g_lane
         logic signed [psum_bw-1:0] acc_reg;
         logic signed [psum_bw-1:0] lane_in;
         logic signed [psum_bw-1:0] sat_sum;
         logic signed [psum_bw:0]   sum;

         assign lane_in = ofifo_data[gi*psum_bw +: psum_bw];
         // One guard bit: overflow shows up as the top two bits disagreeing.
         assign sum = {acc_reg[psum_bw-1], acc_reg} + {lane_in[psum_bw-1], lane_in};

         always_comb begin
            if (sum[psum_bw] != sum[psum_bw-1])
               sat_sum = sum[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}}
                                      : {1'b0, {(psum_bw-1){1'b1}}};
            else
               sat_sum = sum[psum_bw-1:0];
         end

         // The first vector of a window overwrites, discarding the previous window.
         always_ff @(posedge clk or posedge reset) begin
            if (reset)       acc_reg <= '0;
            else if (accept) acc_reg <= window_first ? lane_in : sat_sum;
         end

         assign wr_data[gi*psum_bw +: psum_bw] = (relu_reg && acc_reg[psum_bw-1]) ? '0 : acc_reg;
      end
   endgenerate

endmodule

// File: tb/tb_psum_drain_wb.sv
module tb_psum_drain_wb;
   localparam int COL  = 8;
   localparam int PBW  = 16;
   localparam int W    = 3;
   localparam int AW   = 11;
   localparam int DW   = COL * PBW;
   localparam int MAXV = 32767;
   localparam int MINV = -32768;

   logic          clk = 1'b0;
   logic          reset, start, relu_en, ofifo_valid;
   logic [AW-1:0] base_addr;
   logic [7:0]    num_out;
   logic [DW-1:0] ofifo_data;
   logic          ofifo_rd, pmem_wr, busy, done;
   logic [AW-1:0] pmem_addr;
   logic [DW-1:0] pmem_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   psum_drain_wb #(.col(COL), .psum_bw(PBW), .WINDOW_SIZE(W), .addr_bw(AW)) dut (
      .clk(clk), .reset(reset), .start(start), .relu_en(relu_en),
      .base_addr(base_addr), .num_out(num_out), .ofifo_valid(ofifo_valid),
      .ofifo_data(ofifo_data), .ofifo_rd(ofifo_rd), .pmem_wr(pmem_wr),
      .pmem_addr(pmem_addr), .pmem_data(pmem_data), .busy(busy), .done(done)
   );

`define CHECK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed=%0h expected=%0h", tag, (obs), (exp)); end end

   logic [DW-1:0] job_vecs[$];
   logic [DW-1:0] vec_q[$];
   int            exp_addr[$];
   logic [DW-1:0] exp_data[$];
   int            w_addr[$];
   logic [DW-1:0] w_data[$];
   int            w_cyc[$];
   int            a_cyc[$];
   logic [DW-1:0] saved;

   function automatic int rand_lane();
      case ($urandom_range(0, 3))
         0:       return int'($urandom_range(0, 65535)) - 32768;
         1:       return int'($urandom_range(0, 40000)) - 20000;
         default: return int'($urandom_range(0, 400)) - 200;
      endcase
   endfunction

   function automatic logic [DW-1:0] rand_vec();
      logic [DW-1:0] v;
      for (int l = 0; l < COL; l++) begin
         int x;
         x = rand_lane();
         v[l*PBW +: PBW] = x[PBW-1:0];
      end
      return v;
   endfunction

   function automatic logic [DW-1:0] splat(input int x);
      logic [DW-1:0] v;
      for (int l = 0; l < COL; l++) v[l*PBW +: PBW] = x[PBW-1:0];
      return v;
   endfunction

   // Reference: each result is the running saturated sum of W consecutive
   // vectors, clamped after every addition, then optionally rectified.
   task automatic build_expected(input bit r, input int b, input int n);
      exp_addr.delete();
      exp_data.delete();
      for (int k = 0; k < n; k++) begin
         logic [DW-1:0] d;
         for (int l = 0; l < COL; l++) begin
            int s;
            s = 0;
            for (int j = 0; j < W; j++) begin
               logic [DW-1:0] v;
               int x;
               v = job_vecs[k*W + j];
               x = int'($signed(v[l*PBW +: PBW]));
               s = (j == 0) ? x : s + x;
               if (s > MAXV) s = MAXV;
               if (s < MINV) s = MINV;
            end
            if (r && s < 0) s = 0;
            d[l*PBW +: PBW] = s[PBW-1:0];
         end
         exp_addr.push_back((b + k) % (1 << AW));
         exp_data.push_back(d);
      end
   endtask

   // Runs one job from job_vecs (which must hold at least 2 spare vectors)
   // and checks writes, pops, done, latency and idle behaviour.
   task automatic run_job(input bit r, input int b, input int n, input int stall_at,
                          input int stall_len, input bit rnd_gap, input int mid_start_cyc);
      int cyc, pops, dones, stall_cnt, hold_err, gap_bad, done_cyc;
      bit finished, popped, have_wr, in_stall, busy_c0;
      logic [AW-1:0] last_a;
      logic [DW-1:0] last_d;
      cyc = 0; pops = 0; dones = 0; stall_cnt = 0; hold_err = 0; gap_bad = 0;
      done_cyc = -1; finished = 0; have_wr = 0; in_stall = 0; busy_c0 = 0;
      last_a = '0; last_d = '0;
      w_addr.delete(); w_data.delete(); w_cyc.delete(); a_cyc.delete();
      build_expected(r, b, n);
      vec_q = job_vecs;

      @(posedge clk); #1;
      start = 1'b1; relu_en = r; base_addr = AW'(b); num_out = 8'(n);
      ofifo_valid = 1'b1; ofifo_data = vec_q[0];
      @(posedge clk); #1;
      start = 1'b0; relu_en = ~r; base_addr = AW'($urandom); num_out = 8'($urandom);

      while (!finished && cyc < 400) begin
         @(negedge clk);
         if (cyc == 0) busy_c0 = busy;
         if (pmem_wr) begin
            w_addr.push_back(int'(pmem_addr)); w_data.push_back(pmem_data); w_cyc.push_back(cyc);
            have_wr = 1; last_a = pmem_addr; last_d = pmem_data;
         end else if (have_wr && (pmem_addr !== last_a || pmem_data !== last_d)) begin
            hold_err++;
         end
         popped = ofifo_rd;
         if (ofifo_rd) a_cyc.push_back(cyc);
         if (in_stall && (ofifo_rd || pmem_wr)) gap_bad++;
         if (done) begin dones++; finished = 1; done_cyc = cyc; end
         @(posedge clk); #1;
         if (popped && vec_q.size() > 0) begin void'(vec_q.pop_front()); pops++; end
         start = (cyc == mid_start_cyc);
         if (start) begin base_addr = AW'(b + 77); num_out = 8'(n + 3); relu_en = ~r; end
         in_stall = (stall_len > 0) && (pops == stall_at) && (stall_cnt < stall_len);
         if (in_stall) stall_cnt++;
         ofifo_valid = (vec_q.size() > 0) && !in_stall && (!rnd_gap || $urandom_range(0, 3) != 0);
         ofifo_data  = (vec_q.size() > 0) ? vec_q[0] : rand_vec();
         cyc++;
      end

      `CHECK("job_timeout", finished, 1'b1)
      `CHECK("busy_after_start", busy_c0, 1'b1)
      `CHECK("done_pulses", dones, 1)
      `CHECK("pop_count", pops, n * W)
      `CHECK("write_count", w_addr.size(), n)
      for (int k = 0; k < n && k < w_addr.size(); k++) begin
         `CHECK("write_addr", w_addr[k], exp_addr[k])
         `CHECK("write_data", w_data[k], exp_data[k])
         if (a_cyc.size() >= (k + 1) * W)
            `CHECK("write_latency", w_cyc[k], a_cyc[(k+1)*W - 1] + 1)
      end
      `CHECK("pmem_hold", hold_err, 0)
      if (stall_len > 0) begin
         `CHECK("stall_gap_quiet", gap_bad, 0)
         `CHECK("stall_cycles", stall_cnt, stall_len)
      end
      if (n == 0) `CHECK("empty_done_cycle", done_cyc, 0)

      ofifo_valid = 1'b1;
      @(negedge clk);
      `CHECK("idle_busy", busy, 1'b0)
      `CHECK("idle_no_pop", ofifo_rd, 1'b0)
      `CHECK("idle_no_write", pmem_wr, 1'b0)
      $display("job relu=%0d base=%0d n=%0d pops=%0d writes=%0d done_cyc=%0d",
               r, b, n, pops, w_addr.size(), done_cyc);
   endtask

   task automatic fill_random(input int nvec);
      job_vecs.delete();
      for (int i = 0; i < nvec; i++) job_vecs.push_back(rand_vec());
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; relu_en = 1'b0; base_addr = '0; num_out = '0;
      ofifo_valid = 1'b0; ofifo_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      `CHECK("reset_busy", busy, 1'b0)
      `CHECK("reset_done", done, 1'b0)
      `CHECK("reset_pmem_wr", pmem_wr, 1'b0)
      `CHECK("reset_pmem_addr", pmem_addr, 11'd0)
      `CHECK("reset_pmem_data", pmem_data, 128'd0)
      reset = 1'b0;

      // Basic job: vectors 1..6 in every lane.
      job_vecs.delete();
      for (int i = 1; i <= 6; i++) job_vecs.push_back(splat(i));
      job_vecs.push_back(splat(100)); job_vecs.push_back(splat(200));
      run_job(1'b0, 5, 2, -1, 0, 1'b0, -1);
      if (w_data.size() >= 2) begin
         `CHECK("basic_first_sum", w_data[0], splat(6))
         `CHECK("basic_second_sum", w_data[1], splat(15))
      end

      // ReLU and positive saturation.
      fill_random(5);
      for (int j = 0; j < 3; j++) begin
         job_vecs[j][15:0]  = 16'hFFF6;   // -10
         job_vecs[j][31:16] = 16'd20000;
      end
      run_job(1'b1, 40, 1, -1, 0, 1'b0, -1);
      if (w_data.size() >= 1) begin
         `CHECK("relu_lane0", w_data[0][15:0], 16'd0)
         `CHECK("sat_pos_lane1", w_data[0][31:16], 16'd32767)
      end

      // Negative saturation without ReLU.
      fill_random(5);
      for (int j = 0; j < 3; j++) job_vecs[j][15:0] = 16'hB1E0;   // -20000
      run_job(1'b0, 41, 1, -1, 0, 1'b0, -1);
      if (w_data.size() >= 1) `CHECK("sat_neg_lane0", w_data[0][15:0], 16'h8000)

      // Stall between 2nd and 3rd vector gives the same result as no stall.
      fill_random(5);
      run_job(1'b0, 300, 1, -1, 0, 1'b0, -1);
      saved = (w_data.size() >= 1) ? w_data[0] : '0;
      run_job(1'b0, 300, 1, 2, 4, 1'b0, -1);
      if (w_data.size() >= 1) `CHECK("stall_same_result", w_data[0], saved)

      // Address wrap at the top of PMEM.
      fill_random(8);
      run_job(1'b1, 2047, 2, -1, 0, 1'b0, -1);

      // Zero-length job.
      fill_random(2);
      run_job(1'b0, 9, 0, -1, 0, 1'b0, -1);

      // start pulsed mid-RUN must be ignored.
      fill_random(11);
      run_job(1'b0, 600, 3, -1, 0, 1'b0, 2);

      // Randomised jobs with random valid gaps.
      for (int t = 0; t < 5; t++) begin
         int n;
         n = int'($urandom_range(1, 4));
         fill_random(n * W + 2);
         run_job(1'($urandom_range(0, 1)), int'($urandom_range(0, 2047)), n, -1, 0, 1'b1, -1);
      end

      // Reset after two accepts of a window.
      fill_random(5);
      vec_q = job_vecs;
      @(posedge clk); #1;
      start = 1'b1; relu_en = 1'b0; base_addr = 11'd100; num_out = 8'd1;
      ofifo_valid = 1'b1; ofifo_data = vec_q[0];
      @(posedge clk); #1;
      start = 1'b0;
      for (int j = 0; j < 2; j++) begin
         @(posedge clk); #1;
         void'(vec_q.pop_front());
         ofifo_data = vec_q[0];
      end
      `CHECK("pre_reset_busy", busy, 1'b1)
      #2 reset = 1'b1;
      #1;
      `CHECK("midreset_ofifo_rd", ofifo_rd, 1'b0)
      `CHECK("midreset_busy", busy, 1'b0)
      `CHECK("midreset_done", done, 1'b0)
      `CHECK("midreset_pmem_wr", pmem_wr, 1'b0)
      `CHECK("midreset_pmem_addr", pmem_addr, 11'd0)
      `CHECK("midreset_pmem_data", pmem_data, 128'd0)
      $display("reset asserted mid-window");
      @(posedge clk); #1;
      reset = 1'b0;
      ofifo_valid = 1'b0;

      fill_random(5);
      run_job(1'b0, 100, 1, -1, 0, 1'b0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
